// File: rtl/mem_stage_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage_ctrl
// Description : MEM-stage controller. Converts MemRead/MemWrite from the
//               EX/MEM register into a req/ack transaction on a multi-cycle
//               data memory port. It stalls the upstream pipeline while the
//               access is outstanding and presents load data to MEM/WB.
//               Optional feature macro: MEM_TIMEOUT_EN. When it is defined,
//               an access with no ack is aborted after MAX_WAIT WAIT cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_stage_ctrl
`ifdef MEM_TIMEOUT_EN
#(
    parameter int MAX_WAIT = 15
)
`endif
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] ALUResult_i,
    input  logic [31:0] RS2data_i,
    input  logic        MemRead_i,
    input  logic        MemWrite_i,
    output logic        stall_o,
    output logic [31:0] rdata_o,
    output logic        rdata_valid_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i,
    output logic        mem_err_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

`ifdef MEM_TIMEOUT_EN
    // The counter value reached in the last WAIT cycle that is allowed
    localparam logic [3:0] c_LIMIT = 4'(MAX_WAIT - 1);
`endif

    logic [1:0]  r_state;
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
`ifdef MEM_TIMEOUT_EN
    logic [3:0]  r_cnt;
    logic        r_err;
`endif

    logic w_access;
    logic w_idle;
    logic w_wait;
    logic w_done;

    // State decode plus the same-cycle access term seen in IDLE
    always_comb begin
        w_access = MemRead_i | MemWrite_i;
        w_idle   = (r_state == S_IDLE);
        w_wait   = (r_state == S_WAIT);
        w_done   = (r_state == S_DONE);
    end

    // Transaction FSM; the latched request stays stable through WAIT
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_we    <= 1'b0;
            r_addr  <= 32'h0;
            r_wdata <= 32'h0;
            r_rdata <= 32'h0;
`ifdef MEM_TIMEOUT_EN
            r_cnt   <= 4'h0;
            r_err   <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_access) begin
                        // A simultaneous read and write is issued as a write
                        r_we    <= MemWrite_i;
                        r_addr  <= {ALUResult_i[31:2], 2'b00};
                        r_wdata <= RS2data_i;
                        r_state <= S_WAIT;
`ifdef MEM_TIMEOUT_EN
                        r_cnt   <= 4'h0;
                        r_err   <= 1'b0;
`endif
                    end
                end
                S_WAIT: begin
                    if (mem_ack_i) begin
                        // Ack wins over a timeout reached in the same cycle
                        if (!r_we) begin
                            r_rdata <= mem_rdata_i;
                        end
                        r_state <= S_DONE;
                    end
`ifdef MEM_TIMEOUT_EN
                    else if (r_cnt == c_LIMIT) begin
                        r_err   <= 1'b1;
                        if (!r_we) begin
                            r_rdata <= 32'h0;
                        end
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 4'h1;
                    end
`endif
                end
                S_DONE: begin
                    // EX/MEM advances this cycle; inputs are not looked at
`ifdef MEM_TIMEOUT_EN
                    r_err   <= 1'b0;
`endif
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Output decode: registered state only, except stall which also
    // reflects a new request arriving in IDLE
    always_comb begin
        stall_o       = (w_idle & w_access) | w_wait;
        mem_req_o     = w_wait;
        mem_we_o      = r_we;
        mem_addr_o    = r_addr;
        mem_wdata_o   = r_wdata;
        rdata_o       = r_rdata;
        rdata_valid_o = w_done & ~r_we;
`ifdef MEM_TIMEOUT_EN
        mem_err_o     = w_done & r_err;
`else
        mem_err_o     = 1'b0;
`endif
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_stage_ctrl
// Description : Directed self-checking bench for mem_stage_ctrl. Inputs are
//               driven on the falling edge; outputs are sampled 1 ns later.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_stage_ctrl;

    logic        clk;
    logic        rst;
    logic [31:0] alu;
    logic [31:0] rs2;
    logic        mrd;
    logic        mwr;
    logic        stall;
    logic [31:0] rdata;
    logic        rvalid;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ack;
    logic [31:0] mrdata;
    logic        err;

    int n_cmp;
    int n_fail;

    mem_stage_ctrl dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .ALUResult_i   (alu),
        .RS2data_i     (rs2),
        .MemRead_i     (mrd),
        .MemWrite_i    (mwr),
        .stall_o       (stall),
        .rdata_o       (rdata),
        .rdata_valid_o (rvalid),
        .mem_req_o     (req),
        .mem_we_o      (we),
        .mem_addr_o    (addr),
        .mem_wdata_o   (wdata),
        .mem_ack_i     (ack),
        .mem_rdata_i   (mrdata),
        .mem_err_o     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset;
        int bad;
        rst = 1'b1; alu = '0; rs2 = '0; mrd = 1'b0; mwr = 1'b0; ack = 1'b0; mrdata = '0;
        @(negedge clk); #1;
        n_cmp++; if ({stall, req, rvalid, err} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_ctrl: got %b required 0000", {stall, req, rvalid, err});
        end
        n_cmp++; if (rdata !== 32'h0) begin
            n_fail++; $display("FAIL reset_rdata: got %h required 00000000", rdata);
        end
        @(negedge clk); rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            ack = (i == 2) || (i == 3);  // spurious ack while idle
            mrdata = 32'hFFFF_FFFF;
            #1;
            if (stall || req || err || rvalid || rdata !== 32'h0) bad++;
        end
        ack = 1'b0;
        n_cmp++; if (bad !== 0) begin
            n_fail++; $display("FAIL idle_quiet: got %0d bad cycles required 0", bad);
        end
    endtask

    task automatic test_load;
        int nstall;
        int bad;
        @(negedge clk);
        mrd = 1'b1; alu = 32'h0000_0107; rs2 = 32'h5555_5555; #1;
        nstall = stall ? 1 : 0;
        n_cmp++; if ({stall, req} !== 2'b10) begin
            n_fail++; $display("FAIL load_idle_cycle: got stall/req %b required 10", {stall, req});
        end
        bad = 0;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            ack = (i == 3); mrdata = (i == 3) ? 32'hCAFE_F00D : 32'h0;
            #1;
            if (stall) nstall++;
            if (!req || we !== 1'b0 || addr !== 32'h0000_0104) bad++;
        end
        n_cmp++; if (bad !== 0) begin
            n_fail++; $display("FAIL load_wait_bus: got %0d bad cycles required 0 (addr %h we %b)", bad, addr, we);
        end
        @(negedge clk);
        ack = 1'b0; mrd = 1'b0; #1;
        if (stall) nstall++;
        n_cmp++; if ({req, rvalid} !== 2'b01 || rdata !== 32'hCAFE_F00D) begin
            n_fail++; $display("FAIL load_done: got req/valid %b rdata %h required 01 cafef00d", {req, rvalid}, rdata);
        end
        n_cmp++; if (nstall !== 4) begin
            n_fail++; $display("FAIL load_stall_count: got %0d required 4", nstall);
        end
        @(negedge clk); #1;
        n_cmp++; if (rvalid !== 1'b0 || rdata !== 32'hCAFE_F00D) begin
            n_fail++; $display("FAIL load_hold: got valid %b rdata %h required 0 cafef00d", rvalid, rdata);
        end
    endtask

    task automatic test_store;
        int nstall;
        @(negedge clk);
        mwr = 1'b1; alu = 32'h0000_0020; rs2 = 32'h1234_5678; #1;
        nstall = stall ? 1 : 0;
        @(negedge clk);
        ack = 1'b1; mrdata = 32'hBAD0_BAD0; #1;
        if (stall) nstall++;
        n_cmp++; if ({req, we} !== 2'b11 || addr !== 32'h20 || wdata !== 32'h1234_5678) begin
            n_fail++; $display("FAIL store_bus: got req/we %b addr %h wdata %h required 11 00000020 12345678", {req, we}, addr, wdata);
        end
        @(negedge clk);
        ack = 1'b0; mwr = 1'b0; #1;
        if (stall) nstall++;
        n_cmp++; if (rvalid !== 1'b0 || rdata !== 32'hCAFE_F00D || req !== 1'b0) begin
            n_fail++; $display("FAIL store_done: got valid %b req %b rdata %h required 0 0 cafef00d", rvalid, req, rdata);
        end
        n_cmp++; if (nstall !== 2) begin
            n_fail++; $display("FAIL store_stall_count: got %0d required 2", nstall);
        end
    endtask

    task automatic test_read_write_both;
        int bad;
        @(negedge clk);
        mrd = 1'b1; mwr = 1'b1; alu = 32'h0000_0033; rs2 = 32'hA5A5_0F0F; #1;
        bad = 0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); #1;
            if (!req || we !== 1'b1 || addr !== 32'h30 || wdata !== 32'hA5A5_0F0F) bad++;
        end
        n_cmp++; if (bad !== 0) begin
            n_fail++; $display("FAIL both_is_write: got %0d bad cycles required 0 (we %b addr %h)", bad, we, addr);
        end
        @(negedge clk); ack = 1'b1; mrdata = 32'h7777_7777;
        @(negedge clk); mrd = 1'b0; mwr = 1'b0; #1;  // DONE, ack still high
        n_cmp++; if ({req, rvalid, stall} !== 3'b000) begin
            n_fail++; $display("FAIL both_done: got req/valid/stall %b required 000", {req, rvalid, stall});
        end
        @(negedge clk); #1;  // IDLE with ack still high
        @(negedge clk); #1;
        ack = 1'b0;
        n_cmp++; if (req !== 1'b0 || rdata !== 32'hCAFE_F00D) begin
            n_fail++; $display("FAIL spurious_ack: got req %b rdata %h required 0 cafef00d", req, rdata);
        end
    endtask

    task automatic test_back_to_back;
        // Load stays requested and ack stays high: each access takes 3 cycles
        @(negedge clk);
        mrd = 1'b1; alu = 32'h0000_0008; ack = 1'b1; mrdata = 32'h1111_1111; #1;
        @(negedge clk); #1;
        n_cmp++; if (req !== 1'b1 || addr !== 32'h8) begin
            n_fail++; $display("FAIL b2b_first_req: got req %b addr %h required 1 00000008", req, addr);
        end
        @(negedge clk);
        alu = 32'h0000_0010; mrdata = 32'h2222_2222; #1;
        n_cmp++; if (rvalid !== 1'b1 || rdata !== 32'h1111_1111) begin
            n_fail++; $display("FAIL b2b_first_done: got valid %b rdata %h required 1 11111111", rvalid, rdata);
        end
        @(negedge clk); #1;
        n_cmp++; if ({stall, req, rvalid} !== 3'b100) begin
            n_fail++; $display("FAIL b2b_second_idle: got stall/req/valid %b required 100", {stall, req, rvalid});
        end
        @(negedge clk); #1;
        n_cmp++; if (req !== 1'b1 || addr !== 32'h10) begin
            n_fail++; $display("FAIL b2b_second_req: got req %b addr %h required 1 00000010", req, addr);
        end
        @(negedge clk);
        mrd = 1'b0; ack = 1'b0; #1;
        n_cmp++; if (rvalid !== 1'b1 || rdata !== 32'h2222_2222) begin
            n_fail++; $display("FAIL b2b_second_done: got valid %b rdata %h required 1 22222222", rvalid, rdata);
        end
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        mrd = 1'b1; alu = 32'h0000_0040; #1;
        @(negedge clk); #1;
        @(negedge clk); #1;
        n_cmp++; if (req !== 1'b1) begin
            n_fail++; $display("FAIL rstmid_pre: got req %b required 1", req);
        end
        rst = 1'b1; mrd = 1'b0; #1;
        n_cmp++; if ({req, stall} !== 2'b00 || rdata !== 32'h0) begin
            n_fail++; $display("FAIL rstmid_async: got req/stall %b rdata %h required 00 00000000", {req, stall}, rdata);
        end
        @(negedge clk); rst = 1'b0;
        @(negedge clk); #1;
        n_cmp++; if ({req, stall, rvalid} !== 3'b000) begin
            n_fail++; $display("FAIL rstmid_idle: got req/stall/valid %b required 000", {req, stall, rvalid});
        end
        // Recovery: a fresh load leaves a nonzero value for later tests
        @(negedge clk);
        mrd = 1'b1; alu = 32'h0000_0084; #1;
        @(negedge clk);
        ack = 1'b1; mrdata = 32'hDEAD_BEEF; #1;
        @(negedge clk);
        ack = 1'b0; mrd = 1'b0; #1;
        n_cmp++; if (rvalid !== 1'b1 || rdata !== 32'hDEAD_BEEF) begin
            n_fail++; $display("FAIL rstmid_recover: got valid %b rdata %h required 1 deadbeef", rvalid, rdata);
        end
    endtask

`ifdef MEM_TIMEOUT_EN
    task automatic test_timeout;
        int waits;
        bit done;
        @(negedge clk);
        mrd = 1'b1; alu = 32'h0000_0200; #1;
        waits = 0; done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk); #1;
            if (req) waits++; else done = 1'b1;
        end
        mrd = 1'b0;
        n_cmp++; if (!done || waits !== 15) begin
            n_fail++; $display("FAIL timeout_len: got %0d wait cycles (done %b) required 15", waits, done);
        end
        n_cmp++; if ({err, rvalid} !== 2'b11 || rdata !== 32'h0) begin
            n_fail++; $display("FAIL timeout_abort: got err/valid %b rdata %h required 11 00000000", {err, rvalid}, rdata);
        end
        @(negedge clk); #1;
        n_cmp++; if (err !== 1'b0) begin
            n_fail++; $display("FAIL timeout_err_pulse: got err %b required 0", err);
        end
        // Ack in the 15th WAIT cycle completes normally
        @(negedge clk);
        mrd = 1'b1; alu = 32'h0000_0204; #1;
        waits = 0; done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk); #1;
            if (req) begin
                waits++;
                if (waits == 15) begin ack = 1'b1; mrdata = 32'h0BAD_BEEF; end
            end else begin
                done = 1'b1;
            end
        end
        ack = 1'b0; mrd = 1'b0;
        n_cmp++; if (!done || waits !== 15 || err !== 1'b0 || rvalid !== 1'b1 || rdata !== 32'h0BAD_BEEF) begin
            n_fail++; $display("FAIL timeout_ack_wins: got waits %0d err %b valid %b rdata %h required 15 0 1 0badbeef", waits, err, rvalid, rdata);
        end
    endtask
`else
    task automatic test_long_wait;
        int nreq;
        int nerr;
        @(negedge clk);
        mrd = 1'b1; alu = 32'h0000_0300; #1;
        nreq = 0; nerr = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); #1;
            if (req) nreq++;
            if (err) nerr++;
        end
        n_cmp++; if (nreq !== 20 || nerr !== 0) begin
            n_fail++; $display("FAIL long_wait_hold: got req cycles %0d err cycles %0d required 20 0", nreq, nerr);
        end
        ack = 1'b1; mrdata = 32'h0BAD_BEEF;
        @(negedge clk);
        ack = 1'b0; mrd = 1'b0; #1;
        n_cmp++; if (err !== 1'b0 || rvalid !== 1'b1 || rdata !== 32'h0BAD_BEEF) begin
            n_fail++; $display("FAIL long_wait_done: got err %b valid %b rdata %h required 0 1 0badbeef", err, rvalid, rdata);
        end
    endtask
`endif

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        test_reset();
        test_load();
        test_store();
        test_read_write_both();
        test_back_to_back();
        test_reset_mid();
`ifdef MEM_TIMEOUT_EN
        test_timeout();
`else
        test_long_wait();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
